// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_STALL = 2'd1,
        SEQ_REDIR = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// EX-stage resolution inputs and instruction-fetch port seen by the sequencer.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic            ex_valid;
    logic            ex_is_ctrl;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            hazard_stall;
    logic            imem_ready;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_req;
    logic            flush_if_id;
    logic            flush_id_ex;

    modport master (
        output ex_valid, ex_is_ctrl, ex_taken, ex_target, hazard_stall, imem_ready,
        input  fetch_pc, fetch_req, flush_if_id, flush_id_ex
    );

    modport slave (
        input  ex_valid, ex_is_ctrl, ex_taken, ex_target, hazard_stall, imem_ready,
        output fetch_pc, fetch_req, flush_if_id, flush_id_ex
    );

endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_value <= '0;
        end else if (i_inc && (r_value != '1)) begin
            r_value <= r_value + W'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: static not-taken sequencing, EX redirects with flushes,
// terminal halt on misaligned targets, and two saturating perf counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    pc_sequencer_if.slave    bus,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    seq_state_e      r_state;
    seq_state_e      w_next_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_tgt;
    logic            w_halted;
    logic            w_redir;
    logic            w_mis;
    logic            w_ctrl_seen;

    // Bit 0 is dropped (JALR semantics); bit 1 set means a misaligned target.
    assign w_halted    = (r_state == SEQ_HALT);
    assign w_tgt       = {bus.ex_target[PC_W-1:1], 1'b0};
    assign w_redir     = bus.ex_valid & bus.ex_is_ctrl & bus.ex_taken & ~w_halted;
    assign w_mis       = w_redir & w_tgt[1];
    assign w_ctrl_seen = bus.ex_valid & bus.ex_is_ctrl & ~w_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEQ_RUN;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
        end
    end

    // Redirect outranks stall: the stalled instruction is being squashed anyway.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_fetch_pc;
        if (w_halted || w_mis) begin
            w_next_state = SEQ_HALT;
        end else if (w_redir) begin
            w_next_state = SEQ_REDIR;
            w_next_pc    = w_tgt;
        end else if (bus.hazard_stall || !bus.imem_ready) begin
            w_next_state = SEQ_STALL;
        end else begin
            w_next_state = SEQ_RUN;
            w_next_pc    = r_fetch_pc + PC_STEP;
        end
    end

    // The fetch in flight during a redirect is stale, so no request that cycle.
    always_comb begin
        bus.fetch_pc    = r_fetch_pc;
        bus.fetch_req   = ~w_halted & ~w_redir;
        bus.flush_if_id = w_redir;
        bus.flush_id_ex = w_redir;
        o_halted        = w_halted;
    end

    sat_counter #(.W(CNT_W)) u_ctrl_cnt (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (w_ctrl_seen),
        .o_value (o_ctrl_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (w_redir & ~w_mis),
        .o_value (o_redirect_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Drives two sequencers (default build and a high-reset-PC / 8-bit-counter build)
// with identical stimulus and compares both against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        halted0, halted1;
    logic [31:0] cc0, rc0;
    logic [7:0]  cc1, rc1;

    pc_sequencer_if bus0 ();
    pc_sequencer_if bus1 ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .o_halted(halted0), .o_ctrl_cnt(cc0), .o_redirect_cnt(rc0)
    );

    pc_sequencer #(.RESET_PC(RPC1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .o_halted(halted1), .o_ctrl_cnt(cc1), .o_redirect_cnt(rc1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state per instance: expected PC, halt flag and event counts.
    logic [31:0] m_pc[2];
    bit          m_halt[2];
    longint      m_cc[2];
    longint      m_rc[2];
    longint      m_max[2];
    logic [31:0] m_rst_pc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit c, input bit t, input logic [31:0] tgt,
                        input bit stall, input bit ready, input bit r);
        bit          redir[2];
        logic [31:0] tm;
        rst               = r;
        bus0.ex_valid     = v;     bus1.ex_valid     = v;
        bus0.ex_is_ctrl   = c;     bus1.ex_is_ctrl   = c;
        bus0.ex_taken     = t;     bus1.ex_taken     = t;
        bus0.ex_target    = tgt;   bus1.ex_target    = tgt;
        bus0.hazard_stall = stall; bus1.hazard_stall = stall;
        bus0.imem_ready   = ready; bus1.imem_ready   = ready;
        #1;
        for (int d = 0; d < 2; d++) redir[d] = v && c && t && !m_halt[d];
        chk("flush_if_id0", 32'(bus0.flush_if_id), 32'(redir[0]));
        chk("flush_id_ex0", 32'(bus0.flush_id_ex), 32'(redir[0]));
        chk("fetch_req0",   32'(bus0.fetch_req),   32'(!m_halt[0] && !redir[0]));
        chk("flush_if_id1", 32'(bus1.flush_if_id), 32'(redir[1]));
        chk("flush_id_ex1", 32'(bus1.flush_id_ex), 32'(redir[1]));
        chk("fetch_req1",   32'(bus1.fetch_req),   32'(!m_halt[1] && !redir[1]));
        @(posedge clk);
        #1;
        tm = tgt & ~32'd1;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_pc[d] = m_rst_pc[d]; m_halt[d] = 0; m_cc[d] = 0; m_rc[d] = 0;
            end else if (!m_halt[d]) begin
                if (v && c && m_cc[d] < m_max[d]) m_cc[d]++;
                if (redir[d]) begin
                    if ((tm % 4) != 0) m_halt[d] = 1;
                    else begin
                        m_pc[d] = tm;
                        if (m_rc[d] < m_max[d]) m_rc[d]++;
                    end
                end else if (!stall && ready) begin
                    m_pc[d] = m_pc[d] + 32'd4;
                end
            end
        end
        chk("fetch_pc0",    bus0.fetch_pc, m_pc[0]);
        chk("halted0",      32'(halted0),  32'(m_halt[0]));
        chk("ctrl_cnt0",    cc0,           32'(m_cc[0]));
        chk("redir_cnt0",   rc0,           32'(m_rc[0]));
        chk("fetch_pc1",    bus1.fetch_pc, m_pc[1]);
        chk("halted1",      32'(halted1),  32'(m_halt[1]));
        chk("ctrl_cnt1",    32'(cc1),      32'(m_cc[1]));
        chk("redir_cnt1",   32'(rc1),      32'(m_rc[1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom, 0, 1, 0);
    endtask

    task automatic jump(input logic [31:0] tgt);
        step(1, 1, 1, tgt, 0, 1, 0);
    endtask

    initial begin
        m_max[0] = 64'hFFFF_FFFF; m_max[1] = 255;
        m_rst_pc[0] = 32'h0; m_rst_pc[1] = RPC1;
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 'x; m_halt[d] = 0; m_cc[d] = 0; m_rc[d] = 0;
        end
        rst = 1'b1;
        bus0.ex_valid = 0; bus0.ex_is_ctrl = 0; bus0.ex_taken = 0; bus0.ex_target = 0;
        bus0.hazard_stall = 0; bus0.imem_ready = 1;
        bus1.ex_valid = 0; bus1.ex_is_ctrl = 0; bus1.ex_taken = 0; bus1.ex_target = 0;
        bus1.hazard_stall = 0; bus1.imem_ready = 1;
        @(posedge clk); #1;

        // Reset, then free-running fetch (instance 1 wraps through zero).
        step(0, 0, 0, 32'h0, 0, 1, 1);
        chk("reset_pc0", bus0.fetch_pc, 32'h0);
        chk("reset_pc1", bus1.fetch_pc, RPC1);
        idle(4);
        chk("seq_pc0", bus0.fetch_pc, 32'h10);
        chk("wrap_pc1", bus1.fetch_pc, 32'h8);

        // Taken redirect with bit 0 set in the target.
        jump(32'h101);
        chk("redir_pc0", bus0.fetch_pc, 32'h100);
        chk("redir_cnt_first", rc0, 32'd1);

        // Stall window with a redirect in its second cycle.
        jump(32'h1C);
        idle(1);
        step(0, 0, 0, 32'h0, 1, 1, 0);
        chk("stall_hold", bus0.fetch_pc, 32'h20);
        step(1, 1, 1, 32'h40, 1, 1, 0);
        chk("stall_override", bus0.fetch_pc, 32'h40);
        step(0, 0, 0, 32'h0, 1, 1, 0);
        idle(1);
        chk("after_stall", bus0.fetch_pc, 32'h44);

        // Not-taken branch, memory back-pressure, back-to-back redirects.
        step(1, 1, 0, 32'h500, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        jump(32'h80);
        jump(32'h90);
        chk("b2b_redir", bus0.fetch_pc, 32'h90);
        idle(2);

        // Random traffic with occasional misaligned targets and resets.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            tg = $urandom;
            if ($urandom_range(0, 29) != 0) tg = tg & ~32'h2;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                 tg, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 49) == 0);
        end

        // Misaligned target halts; EX inputs are then ignored until reset.
        step(0, 0, 0, 32'h0, 0, 1, 1);
        idle(2);
        jump(32'h202);
        chk("halt_set", 32'(halted0), 32'd1);
        chk("halt_pc", bus0.fetch_pc, 32'h8);
        for (int i = 0; i < 5; i++) step(1, 1, $urandom_range(0, 1) == 1, $urandom & ~32'h3, 0, 1, 0);
        step(0, 0, 0, 32'h0, 0, 1, 1);
        chk("halt_clear", 32'(halted0), 32'd0);
        chk("halt_reset_pc1", bus1.fetch_pc, RPC1);

        // Saturation of the 8-bit control counter.
        for (int i = 0; i < 300; i++) step(1, 1, 0, $urandom, 0, 1, 0);
        chk("ctrl_sat1", 32'(cc1), 32'd255);
        chk("ctrl_nosat0", cc0, 32'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC register and sequences it. Default is pc+4 (static not-taken). On a taken branch/jump resolved in EX, it redirects to the target computed by the next-PC adder.
- Generates the pipeline flush pulses and tracks a halt state for misaligned targets.
- Sits between the EX-stage next-PC adder outputs and the instruction-memory fetch port. Keeps two performance counters.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
CNT_W, 32, width of performance counters (8..32)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX stage holds a valid instruction this cycle
ex_is_ctrl  input  1  EX instruction is JAL/JALR/Bxx
ex_taken  input  1  control transfer taken (always 1 for JAL/JALR)
ex_target  input  32  npc_op1+npc_op2 from next-PC adder
hazard_stall  input  1  decode hazard; hold PC and IF/ID
imem_ready  input  1  instruction memory accepts fetch_pc this cycle
fetch_pc  output  32  current fetch address
fetch_req  output  1  fetch request valid
flush_if_id  output  1  squash IF/ID register next edge
flush_id_ex  output  1  squash ID/EX register next edge
halted  output  1  sequencer stopped on misaligned target
ctrl_cnt  output  CNT_W  retired control instructions
redirect_cnt  output  CNT_W  taken redirects

Behaviour:
- Reset (synchronous, rst=1 at edge) gives: fetch_pc=RESET_PC, state=RUN, counters=0, halted=0. rst dominates all other inputs, including mid-redirect and HALT.
- States:
  - RUN: normal fetch.
  - STALL: PC held due to hazard or memory.
  - REDIR: one-cycle bubble after redirect.
  - HALT: terminal until rst.
- Masked target: tgt = {ex_target[31:1],1'b0}.
- Redirect condition: redir = ex_valid & ex_is_ctrl & ex_taken & ~halted.
- Misaligned condition: mis = redir & tgt[1].
- Next-state priority, each cycle:
  1. rst
  2. mis -> HALT; fetch_pc unchanged; flushes asserted this cycle
  3. redir -> fetch_pc<=tgt, state<=REDIR
  4. hazard_stall or ~imem_ready -> hold fetch_pc, state<=STALL
  5. otherwise fetch_pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), state<=RUN
- Redirect beats stall. A simultaneous hazard_stall is overridden because the stalled instruction is being squashed.
- flush_if_id and flush_id_ex are combinational: both equal redir (including the mis case). They are asserted in the same cycle the redirect is seen, for exactly one cycle per redirect.
- fetch_req:
  - =0 in HALT, and in the cycle of a redirect (the old fetch is discarded).
  - =1 in RUN, STALL and REDIR.
- REDIR lasts one cycle, then behaves as RUN. Back-to-back redirects are legal. A redirect while in REDIR re-targets normally.
- STALL exits when hazard_stall=0 and imem_ready=1. The PC is held stably for the whole stall.
- Counters, both saturating at all-ones (no wrap):
  - ctrl_cnt increments on ex_valid & ex_is_ctrl.
  - redirect_cnt increments on redir & ~mis.
- halted=1 iff state==HALT. In HALT all ex_* inputs are ignored and the counters freeze.
- Latency: the redirect target appears on fetch_pc one cycle after the EX cycle that resolves it.

Decomposition:
- Shared package: SeqState enum (SEQ_RUN, SEQ_STALL, SEQ_REDIR, SEQ_HALT); PC_STEP=32'd4; RESET_PC default constant.
- One sub-module: sat_counter (parameter W, inputs inc and clear, output value). It is instantiated twice, for ctrl_cnt and redirect_cnt.

Test Plan:
- Reset then 4 free cycles, imem_ready=1 -> fetch_pc 0,4,8,12,16; no flushes; counters 0.
- At fetch_pc=0x10, pulse ex_valid/is_ctrl/taken with ex_target=0x101 -> same cycle both flushes=1 and fetch_req=0; next cycle fetch_pc=0x100; redirect_cnt=1, ctrl_cnt=1.
- hazard_stall=1 for 3 cycles at 0x20, with a taken redirect to 0x40 in stall cycle 2 -> PC holds 0x20, then 0x40, then 0x44; stall is overridden.
- Not-taken branch (ex_taken=0) -> no flush, ctrl_cnt+1, redirect_cnt unchanged, PC continues +4.
- Redirect with ex_target=0x202 -> halted=1 next cycle; fetch_req=0 and PC frozen; later ex inputs ignored; rst -> fetch_pc=RESET_PC, halted=0.
- RESET_PC=0xFFFF_FFF8, CNT_W=8 -> PC wraps 0xFFFF_FFFC->0; 300 not-taken branches leave ctrl_cnt=255 (saturated).
